fpa_arbiter: RTL
================

// Module: fpa_arbiter
// PURPOSE
//  Shares one half-precision fpa_adder between NREQ requesters.
//  Each requester offers an operand pair over a valid/ready handshake. Round-robin arbitration grants one pair per cycle.
//  Tagged results return on a single backpressured response port, buffered by an internal FIFO.
//  Sits between requesters and the adder; the adder itself is instantiated outside this block.
// PARAMETERS
//  NREQ        4  number of requesters (2..8)
//  ADD_LAT     1  clock edges from add_a/b_34 change to valid add_sum_34/flags
//  FIFO_DEPTH  4  response FIFO entries; must be >= ADD_LAT+1
// PORTS
//  clk_34        in   1         clock, rising edge
//  rst_34        in   1         async reset, active-low
//  flush_34      in   1         stop granting, drain in-flight ops
//  req_valid_34  in   NREQ      per-requester operand pair valid
//  req_ready_34  out  NREQ      per-requester grant (one-hot or zero)
//  req_opa_34    in   NREQ*16   operand A, requester i at [16i+15:16i]
//  req_opb_34    in   NREQ*16   operand B, same packing
//  add_a_34      out  16        registered operand A to adder
//  add_b_34      out  16        registered operand B to adder
//  add_sum_34    in   16        adder sum
//  add_ovf_34    in   1         adder overflow flag
//  add_unf_34    in   1         adder underflow flag
//  rsp_valid_34  out  1         response available (FIFO head)
//  rsp_ready_34  in   1         consumer accepts response
//  rsp_sum_34    out  16        result
//  rsp_tag_34    out  $clog2(NREQ)  index of originating requester
//  rsp_ovf_34    out  1         overflow flag of result
//  rsp_unf_34    out  1         underflow flag of result
//  busy_34       out  1         ops in flight or FIFO non-empty
// BEHAVIOUR
//  Reset: add_a/b=0, FSM=IDLE, rr pointer=NREQ-1, in-flight pipe cleared, FIFO empty.
//    All outputs are 0 during reset.
//  FSM:
//    IDLE->RUN when any req_valid.
//    RUN->DRAIN on flush_34.
//    RUN->IDLE when no req_valid and !busy.
//    DRAIN->IDLE when !busy.
//    No grants in IDLE or DRAIN.
//  Credits: grant allowed only if inflight + fifo_count < FIFO_DEPTH. Full FIFO never drops a result.
//  Arbitration: search starts at rr+1 and wraps modulo NREQ. First valid requester is granted; rr <= grantee.
//    req_ready_34 depends combinationally on req_valid_34.
//    Requesters must not make valid depend on ready.
//  Handshake: transfer when valid&ready at an edge. add_a/b_34 load at that edge and hold until the next grant.
//  Tracking: shift register of ADD_LAT stages carries {valid,tag}. At stage end, sum+flags+tag push into the FIFO.
//  Latency: grant edge E -> rsp_valid_34 high after edge E+ADD_LAT+1, when the FIFO was empty.
//  Response: rsp_* show the FIFO head and hold stable while rsp_valid & !rsp_ready. Pop on valid&ready.
//  Simultaneous push and pop: count unchanged, order preserved (FIFO, in grant order).
//  Flush during a grant edge: that grant completes; no further grants.
//  Reset mid-operation: in-flight ops and FIFO contents are discarded, no responses emitted.
// CONFIGURATION
//  FPA_ARB_PRIO0_EN defined: requester 0 wins whenever valid (fixed priority).
//    Others use round-robin, and rr is not updated on requester-0 grants.
//  Undefined: pure round-robin across all NREQ.
// STRUCTURE
//  fpa_pkg: FP16_W=16, fsm state enum {IDLE,RUN,DRAIN}, rsp entry typedef {sum,ovf,unf,tag}.
//  Sub-module fpa_rsp_fifo: synchronous FIFO (depth FIFO_DEPTH, count output, async active-low reset).
// TESTING
//  1. Req0 5620+5948, rsp_ready=1 -> after ADD_LAT+1 edges: rsp_sum=5C2C, tag=0, ovf=unf=0.
//  2. All 4 valid continuously, ready=1 -> grants 0,1,2,3,0...; tags return in the same order.
//  3. rsp_ready=0, continuous requests -> exactly FIFO_DEPTH grants, then req_ready=0.
//     rsp_* stable; ready=1 resumes with no loss.
//  4. Req2 5630+D590 with flush asserted same cycle -> result 4900 tag=2 delivered, FSM DRAIN->IDLE, no further grants.
//  5. Reset asserted with 2 ops in flight -> rsp_valid=0 and busy=0 immediately; no stale response after release.
//  6. FPA_ARB_PRIO0_EN, req0 and req1 always valid -> req1 never granted; macro off -> alternating grants.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared types for the fp16 adder arbiter: widths, control states, response FIFO entry.
// No logic; tag field is sized for the largest supported requester count (8).
package fpa_pkg;
    localparam int FP16_W = 16;
    localparam int TAG_W  = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

    typedef struct packed {
        logic [FP16_W-1:0] sum;
        logic              ovf;
        logic              unf;
        logic [TAG_W-1:0]  tag;
    } rsp_t;
endpackage

// File: rtl/fpa_rsp_fifo.sv
// Response FIFO: holds tagged adder results until the consumer takes them.
// Latency: push visible at head the edge after; head is combinational from storage.
// Backpressure: caller reserves space in advance; a push while full is ignored unless popping.
module fpa_rsp_fifo
    import fpa_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  rsp_t          push_dat,
    input  logic          pop,
    output rsp_t          head,
    output logic [CW-1:0] count
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    rsp_t           mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin share of one fp16 adder among NREQ requesters (FPA_ARB_PRIO0_EN: requester 0 fixed priority).
// Latency: grant edge E -> rsp_valid_34 after edge E+ADD_LAT+1 into an empty FIFO.
// Backpressure: grants only while in-flight + queued results fit the FIFO; rsp port is valid/ready.
module fpa_arbiter
    import fpa_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADD_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int TW = $clog2(NREQ)
) (
    input  logic                   clk_34,
    input  logic                   rst_34,
    input  logic                   flush_34,
    input  logic [NREQ-1:0]        req_valid_34,
    output logic [NREQ-1:0]        req_ready_34,
    input  logic [NREQ*FP16_W-1:0] req_opa_34,
    input  logic [NREQ*FP16_W-1:0] req_opb_34,
    output logic [FP16_W-1:0]      add_a_34,
    output logic [FP16_W-1:0]      add_b_34,
    input  logic [FP16_W-1:0]      add_sum_34,
    input  logic                   add_ovf_34,
    input  logic                   add_unf_34,
    output logic                   rsp_valid_34,
    input  logic                   rsp_ready_34,
    output logic [FP16_W-1:0]      rsp_sum_34,
    output logic [TW-1:0]          rsp_tag_34,
    output logic                   rsp_ovf_34,
    output logic                   rsp_unf_34,
    output logic                   busy_34
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Stage 0 shadows the operand register; stages 1..ADD_LAT follow the adder pipeline.
    localparam int PS = ADD_LAT + 1;

    fsm_t           state;
    logic [TW-1:0]  rr;
    logic [PS-1:0]  pipe_vld;
    logic [TW-1:0]  pipe_tag [PS];
    logic [CW-1:0]  fifo_cnt;
    logic [CW:0]    inflight;
    logic           grant_en;
    logic           found;
    logic           prio_hit;
    logic           fire;
    logic [TW-1:0]  gnt_idx;
    logic           busy;
    rsp_t           push_dat;
    rsp_t           fifo_head;
    logic           unused_tag_bits;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PS; i++) inflight = inflight + (CW+1)'(pipe_vld[i]);
    end

    assign busy     = (|pipe_vld) || (fifo_cnt != '0);
    assign grant_en = (state == RUN) && ((inflight + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        logic [TW-1:0] idx;
        found    = 1'b0;
        prio_hit = 1'b0;
        gnt_idx  = '0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = TW'((int'(rr) + k) % NREQ);
            if (!found && req_valid_34[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
`ifdef FPA_ARB_PRIO0_EN
        if (req_valid_34[0]) begin
            found    = 1'b1;
            prio_hit = 1'b1;
            gnt_idx  = '0;
        end
`endif
    end

    assign fire = found && grant_en;

    always_comb begin
        req_ready_34 = '0;
        if (fire) req_ready_34[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_34 or negedge rst_34) begin
        if (!rst_34) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (|req_valid_34) state <= RUN;
                RUN:     if (flush_34) state <= DRAIN;
                         else if (!(|req_valid_34) && !busy) state <= IDLE;
                DRAIN:   if (!busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_34 or negedge rst_34) begin
        if (!rst_34) begin
            add_a_34 <= '0;
            add_b_34 <= '0;
            rr       <= TW'(NREQ - 1);
            pipe_vld <= '0;
            for (int i = 0; i < PS; i++) pipe_tag[i] <= '0;
        end else begin
            if (fire) begin
                add_a_34 <= req_opa_34[int'(gnt_idx)*FP16_W +: FP16_W];
                add_b_34 <= req_opb_34[int'(gnt_idx)*FP16_W +: FP16_W];
                if (!prio_hit) rr <= gnt_idx;
            end
            pipe_vld    <= {pipe_vld[PS-2:0], fire};
            pipe_tag[0] <= gnt_idx;
            for (int i = 1; i < PS; i++) pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    always_comb begin
        push_dat     = '0;
        push_dat.sum = add_sum_34;
        push_dat.ovf = add_ovf_34;
        push_dat.unf = add_unf_34;
        push_dat.tag = TAG_W'(pipe_tag[PS-1]);
    end

    fpa_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
        .clk      (clk_34),
        .rst_n    (rst_34),
        .push     (pipe_vld[PS-1]),
        .push_dat (push_dat),
        .pop      (rsp_valid_34 && rsp_ready_34),
        .head     (fifo_head),
        .count    (fifo_cnt)
    );

    assign rsp_valid_34    = (fifo_cnt != '0);
    assign rsp_sum_34      = fifo_head.sum;
    assign rsp_ovf_34      = fifo_head.ovf;
    assign rsp_unf_34      = fifo_head.unf;
    assign rsp_tag_34      = fifo_head.tag[TW-1:0];
    assign busy_34         = busy;
    assign unused_tag_bits = ^fifo_head.tag;
endmodule
